// File: rtl/l_func_feeder_if.sv
// ---------------------------------------------------------------------------
// l_func_feeder_if
//
// Bundles the upstream load handshake and the downstream divider burst of
// l_func_feeder into a single interface.
//
//   in_valid      upstream beat valid
//   in_ready      feeder can accept a beat (LOAD only)
//   in_u          u beat, least-significant block first
//   in_n          n beat, sampled on the first NB accepts only
//   div_valid_in  one-cycle job-start pulse to the divider
//   div_data_vld  high for UB consecutive cycles per job
//   div_x         dividend beat (u-1), most-significant block first
//   div_y         divisor beat (n), zero after the first NB beats
//   err_underflow asserted with div_valid_in when u == 0
//   busy          job being handed to the divider
//
// Modports: slave = feeder side, master = environment side.
// ---------------------------------------------------------------------------
interface l_func_feeder_if #(
    parameter int Block = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [Block-1:0] in_u;
    logic [Block-1:0] in_n;
    logic             div_valid_in;
    logic             div_data_vld;
    logic [Block-1:0] div_x;
    logic [Block-1:0] div_y;
    logic             err_underflow;
    logic             busy;

    modport slave (
        input  in_valid, in_u, in_n,
        output in_ready, div_valid_in, div_data_vld, div_x, div_y,
               err_underflow, busy
    );

    modport master (
        output in_valid, in_u, in_n,
        input  in_ready, div_valid_in, div_data_vld, div_x, div_y,
               err_underflow, busy
    );
endinterface

// File: rtl/l_func_feeder.sv
// ---------------------------------------------------------------------------
// l_func_feeder
//
// Upstream feeder for the Paillier L-function divider. Loads u (N bits) and
// n (M bits) as Block-wide beats, LS block first, subtracting 1 from u with
// a serial borrow as the beats arrive. It then issues a start pulse followed
// by UB contiguous beats carrying u-1 and n, MS block first.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  l_func_feeder_if.slave (load handshake + divider burst)
//
// Configuration macro:
//   L_FEED_UNDERFLOW_CHK_EN  when defined, err_underflow flags u == 0 on the
//                            start cycle; when undefined it is tied to 0.
//                            The data path is identical either way.
// ---------------------------------------------------------------------------
module l_func_feeder #(
    parameter int N     = 4096,
    parameter int M     = 2048,
    parameter int Block = 128
) (
    input  logic            clk,
    input  logic            rst,
    l_func_feeder_if.slave  bus
);

    localparam int UB  = N / Block;
    localparam int NB  = M / Block;
    localparam int IW  = (UB > 1) ? $clog2(UB) : 1;
    localparam int NIW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IW-1:0]  LAST_IDX   = IW'(UB - 1);
    localparam logic [NIW-1:0] N_LAST_IDX = NIW'(NB - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_STREAM
    } state_e;

    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic borrow_q, borrow_d;

    logic div_valid_in_q, div_valid_in_d;
    logic div_data_vld_q, div_data_vld_d;
    logic [Block-1:0] div_x_q, div_x_d;
    logic [Block-1:0] div_y_q, div_y_d;
    logic err_underflow_q, err_underflow_d;
    logic busy_q, busy_d;

    // Beat bookkeeping shared between the FSM and the storage write port.
    logic accept;
    logic emit;
    logic [IW-1:0] beat;

    logic [Block-1:0] u_mem [UB];
    logic [Block-1:0] n_mem [NB];

    assign bus.in_ready = (state_q == S_LOAD);

    // -----------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so they can be registered without adding latency.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        idx_d           = idx_q;
        borrow_d        = borrow_q;
        div_valid_in_d  = 1'b0;
        div_data_vld_d  = 1'b0;
        div_x_d         = '0;
        div_y_d         = '0;
        err_underflow_d = 1'b0;
        busy_d          = 1'b0;
        accept          = 1'b0;
        emit            = 1'b0;
        beat            = idx_q;

        unique case (state_q)
            S_LOAD: begin
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    // Borrow survives only while every beat so far was zero.
                    borrow_d = borrow_q & (bus.in_u == '0);
                    idx_d    = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d        = S_START;
                        idx_d          = '0;
                        div_valid_in_d = 1'b1;
                        busy_d         = 1'b1;
`ifdef L_FEED_UNDERFLOW_CHK_EN
                        // A borrow out of the top beat means u was zero.
                        err_underflow_d = borrow_d;
`endif
                    end
                end
            end

            S_START: begin
                state_d = S_STREAM;
                emit    = 1'b1;
                beat    = idx_q;
            end

            S_STREAM: begin
                // idx_q is the beat currently on the outputs.
                if (idx_q == LAST_IDX) begin
                    state_d  = S_LOAD;
                    idx_d    = '0;
                    borrow_d = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                    emit  = 1'b1;
                    beat  = idx_q + IW'(1);
                end
            end

            default: begin
                state_d  = S_LOAD;
                idx_d    = '0;
                borrow_d = 1'b1;
            end
        endcase

        if (emit) begin
            div_data_vld_d = 1'b1;
            busy_d         = 1'b1;
            div_x_d        = u_mem[LAST_IDX - beat];
            if (int'(beat) < NB) begin
                div_y_d = n_mem[N_LAST_IDX - beat[NIW-1:0]];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control and output registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of the others regardless of statement order.
        if (rst) begin
            state_q         <= S_LOAD;
            idx_q           <= '0;
            borrow_q        <= 1'b1;
            div_valid_in_q  <= 1'b0;
            div_data_vld_q  <= 1'b0;
            div_x_q         <= '0;
            div_y_q         <= '0;
            err_underflow_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            borrow_q        <= borrow_d;
            div_valid_in_q  <= div_valid_in_d;
            div_data_vld_q  <= div_data_vld_d;
            div_x_q         <= div_x_d;
            div_y_q         <= div_y_d;
            err_underflow_q <= err_underflow_d;
            busy_q          <= busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Beat storage. u_mem receives u-1 directly, so the stream phase is a
    // plain read-out.
    // -----------------------------------------------------------------------
    // NOTE: the arrays carry no reset; every entry is rewritten during LOAD
    // before it is read, so clearing them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (accept) begin
            u_mem[idx_q] <= bus.in_u - Block'(borrow_q);
            if (int'(idx_q) < NB) begin
                n_mem[idx_q[NIW-1:0]] <= bus.in_n;
            end
        end
    end

    assign bus.div_valid_in  = div_valid_in_q;
    assign bus.div_data_vld  = div_data_vld_q;
    assign bus.div_x         = div_x_q;
    assign bus.div_y         = div_y_q;
    assign bus.err_underflow = err_underflow_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_l_func_feeder.sv
// ---------------------------------------------------------------------------
// tb_l_func_feeder
//
// Directed bench for l_func_feeder. Expected dividend beats come from a
// full-width u-1 subtraction done here; expected divisor beats are sliced
// straight from n. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_l_func_feeder;

    localparam int N     = 4096;
    localparam int M     = 2048;
    localparam int Block = 128;
    localparam int UB    = N / Block;
    localparam int NB    = M / Block;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_checks = 0;
    int n_bad    = 0;

    l_func_feeder_if #(.Block(Block)) bus ();

    l_func_feeder #(.N(N), .M(M), .Block(Block)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [Block-1:0] got,
                         input logic [Block-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic [N-1:0] u);
`ifdef L_FEED_UNDERFLOW_CHK_EN
        return (u == '0);
`else
        return 1'b0;
`endif
    endfunction

    // Called on a falling edge. Presents beats until UB have been accepted;
    // returns on the falling edge after the last accept (the START cycle).
    // in_valid is left as last driven.
    task automatic load_job(input logic [N-1:0] u, input logic [M-1:0] n,
                            input bit stall);
        int  acc   = 0;
        int  guard = 0;
        logic v;
        logic rdy;
        while (acc < UB) begin
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid = v;
            bus.in_u     = u[acc*Block +: Block];
            bus.in_n     = (acc < NB) ? n[acc*Block +: Block]
                                      : {4{$urandom}};
            rdy = bus.in_ready;
            @(negedge clk);
            if (v && rdy) acc++;
            guard++;
            if (guard > 4000) begin
                check("load_timeout", Block'(acc), Block'(UB));
                break;
            end
        end
    endtask

    // Called on the START-cycle falling edge; checks the start pulse, all UB
    // beats and the return to LOAD. Returns on the first LOAD falling edge.
    task automatic check_stream(input string tag, input logic [N-1:0] u,
                                input logic [M-1:0] n, output int start_cyc);
        logic [N-1:0] ue;
        logic [Block-1:0] ey;
        ue = u - N'(1);
        start_cyc = cyc;
        check({tag, "_start"},     Block'(bus.div_valid_in),  Block'(1));
        check({tag, "_start_vld"}, Block'(bus.div_data_vld),  Block'(0));
        check({tag, "_start_err"}, Block'(bus.err_underflow), Block'(exp_err(u)));
        check({tag, "_start_rdy"}, Block'(bus.in_ready),      Block'(0));
        check({tag, "_start_bsy"}, Block'(bus.busy),          Block'(1));
        for (int k = 0; k < UB; k++) begin
            @(negedge clk);
            ey = (k < NB) ? n[(NB-1-k)*Block +: Block] : '0;
            check($sformatf("%s_vld%0d", tag, k), Block'(bus.div_data_vld), Block'(1));
            check($sformatf("%s_x%0d", tag, k), bus.div_x, ue[(UB-1-k)*Block +: Block]);
            check($sformatf("%s_y%0d", tag, k), bus.div_y, ey);
            check($sformatf("%s_ctl%0d", tag, k),
                  Block'({bus.div_valid_in, bus.err_underflow, bus.in_ready, bus.busy}),
                  Block'(4'b0001));
        end
        @(negedge clk);
        check({tag, "_end_vld"}, Block'(bus.div_data_vld), Block'(0));
        check({tag, "_end_x"},   bus.div_x,                '0);
        check({tag, "_end_y"},   bus.div_y,                '0);
        check({tag, "_end_rdy"}, Block'(bus.in_ready),     Block'(1));
        check({tag, "_end_bsy"}, Block'(bus.busy),         Block'(0));
    endtask

    task automatic rand_vec(output logic [N-1:0] u, output logic [M-1:0] n);
        for (int i = 0; i < N/32; i++) u[i*32 +: 32] = $urandom;
        for (int i = 0; i < M/32; i++) n[i*32 +: 32] = $urandom;
    endtask

    initial begin
        logic [N-1:0] u, u2;
        logic [M-1:0] n, n2;
        int s1, s2;

        bus.in_valid = 1'b0;
        bus.in_u     = '0;
        bus.in_n     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_rdy", Block'(bus.in_ready),      Block'(1));
        check("rst_val", Block'(bus.div_valid_in),  Block'(0));
        check("rst_vld", Block'(bus.div_data_vld),  Block'(0));
        check("rst_x",   bus.div_x,                 '0);
        check("rst_y",   bus.div_y,                 '0);
        check("rst_err", Block'(bus.err_underflow), Block'(0));
        check("rst_bsy", Block'(bus.busy),          Block'(0));

        // Decrement without ripple: u = 5, n = 3.
        u = N'(5); n = M'(3);
        load_job(u, n, 1'b0); bus.in_valid = 1'b0;
        check_stream("dec", u, n, s1);

        // Borrow ripple: u = 2^256, n = 7.
        u = '0; u[256] = 1'b1; n = M'(7);
        load_job(u, n, 1'b0); bus.in_valid = 1'b0;
        check_stream("rip", u, n, s1);

        // Underflow: u = 0 wraps to all-ones.
        u = '0; n = M'(11);
        load_job(u, n, 1'b0); bus.in_valid = 1'b0;
        check_stream("unf", u, n, s1);

        // Stall tolerance with random operands.
        for (int j = 0; j < 3; j++) begin
            rand_vec(u, n);
            load_job(u, n, 1'b1); bus.in_valid = 1'b0;
            check_stream($sformatf("stl%0d", j), u, n, s1);
        end

        // Back-to-back with in_valid held high throughout.
        rand_vec(u, n);
        rand_vec(u2, n2);
        load_job(u, n, 1'b0);
        bus.in_u = u2[Block-1:0];
        bus.in_n = n2[Block-1:0];
        check_stream("b2b0", u, n, s1);
        load_job(u2, n2, 1'b0);
        bus.in_valid = 1'b0;
        check_stream("b2b1", u2, n2, s2);
        check("b2b_period", Block'(s2 - s1), Block'(65));

        // Reset on stream beat 10, then a clean job.
        rand_vec(u, n);
        load_job(u, n, 1'b0); bus.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_vld_before", Block'(bus.div_data_vld), Block'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_vld", Block'(bus.div_data_vld), Block'(0));
        check("mid_bsy", Block'(bus.busy),         Block'(0));
        check("mid_rdy", Block'(bus.in_ready),     Block'(1));
        rand_vec(u, n);
        load_job(u, n, 1'b0); bus.in_valid = 1'b0;
        check_stream("post", u, n, s1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/l_func_feeder.md
# l_func_feeder

Upstream feeder for the Paillier L-function divider (`NR_Div`).
- Accepts the operand u (N bits) and modulus n (M bits) as 128-bit beats, least-significant first.
- Computes u−1 serially during the load.
- Re-emits the result most-significant first, in the divider's two-phase burst format: a start pulse, then N/Block contiguous beats.
- Sits between the modular-exponentiation output buffer and `NR_Div`.

## Interface
Parameters:
- N, 4096, width of u and of the dividend.
- M, 2048, width of n and of the divisor.
- Block, 128, beat width; N/Block = UB (32) and M/Block = NB (16) are integers, NB ≤ UB.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  high only in LOAD.
- in_u  in  Block  u beat, LS block first.
- in_n  in  Block  n beat.
  - Sampled on accepts 0..NB−1 only.
  - Ignored on later accepts.
- div_valid_in  out  1  one-cycle job-start pulse to divider (`valid_in`).
- div_data_vld  out  1  high for exactly UB consecutive cycles per job (`data_vld_in`).
- div_x  out  Block  dividend beat (u−1), MS block first.
- div_y  out  Block  divisor beat: n block on beats 0..NB−1, zero after.
- err_underflow  out  1  asserted with div_valid_in when u == 0.
- busy  out  1  high in START and STREAM.

## Operation
- Storage: u_mem[UB][Block] holds u−1; n_mem[NB][Block] holds n. Both are register arrays. One index counter, idx (0..UB−1). One borrow flag, initialised to 1. One zero flag.
- **LOAD** (reset state):
  - in_ready = 1.
  - On accept: u_mem[idx] ← in_u − borrow (mod 2^Block).
  - borrow ← borrow & (in_u == 0).
  - If idx < NB: n_mem[idx] ← in_n.
  - idx increments.
  - On accept with idx == UB−1: go to START, idx ← 0.
- **START**:
  - One cycle; div_valid_in = 1.
  - err_underflow = final borrow (all u beats zero). Result then wraps to 2^N−1, which is still streamed.
  - Go to STREAM.
- **STREAM**:
  - UB cycles; div_data_vld = 1.
  - On beat k: div_x = u_mem[UB−1−k].
  - div_y = n_mem[NB−1−k] for k < NB, else 0.
  - After beat UB−1: LOAD, borrow ← 1.
- No backpressure downstream; the divider consumes every beat.
- in_valid while not LOAD is ignored; no beat is lost because in_ready = 0.
- Reset at any time:
  - FSM → LOAD, idx = 0, borrow = 1.
  - Partial job discarded; storage contents are don't-care.

## Timing
- All outputs are registered. Reset values: in_ready = 1 (combinational from state, LOAD), div_valid_in = 0, div_data_vld = 0, div_x = 0, div_y = 0, err_underflow = 0, busy = 0.
- Last accept at cycle t:
  - div_valid_in high at t+1.
  - div_data_vld high t+2 .. t+UB+1.
  - in_ready high again at t+UB+2.
- Job period, with in_valid held high: UB load + 1 + UB = 65 cycles.
- div_x, div_y and err_underflow are 0 whenever their strobe is low.
- err_underflow holds for the single START cycle only.

## Configuration
- L_FEED_UNDERFLOW_CHK_EN
  - Defined: zero detection and err_underflow as above.
  - Undefined: err_underflow tied to 0, zero-tracking logic removed; data path unchanged (u = 0 still wraps to 2^N−1).

## Test plan
- **Decrement, no ripple.** u = 5, n = 3 (single LS beats, rest zero) → div_valid_in at t+1. Beats k = 0..30: div_x = 0. Beat 31: div_x = 4. Beat 15: div_y = 3, other div_y beats 0. err = 0.
- **Borrow ripple.** u = 2^256, n = 7 → beats 31 and 30: div_x = all-ones. Beat 29: div_x = 0. err = 0.
- **Underflow.** u = 0 → err_underflow = 1 on the START cycle; all 32 div_x beats = all-ones. With the macro undefined, err stays 0.
- **Stall tolerance.** in_valid toggled randomly over 32 accepts, u and n random, a job at a time → reassembled {div_x} == u−1 and the first 16 div_y beats == n, checked against a reference model. div_data_vld stays contiguous.
- **Back-to-back.** Two jobs with in_valid held high → in_ready low for 33 cycles. Second start pulse exactly 65 cycles after the first.
- **Reset mid-stream.** rst asserted on stream beat 10 → next cycle: div_data_vld = 0, busy = 0, in_ready = 1. A following full job streams correctly.
